// File: rtl/count_enable_ctrl_pkg.sv
// Shared encodings for the counter enable controller: run modes, FSM states
// and default widths.
package count_ctrl_pkg;

  localparam int DIV_W_DEF   = 8;
  localparam int BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    MODE_CONT  = 2'b00,
    MODE_BURST = 2'b01,
    MODE_OVF   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic mode_is_valid(input mode_e m);
    return (m != MODE_RSVD);
  endfunction

endpackage

// File: rtl/count_enable_ctrl_if.sv
// Configuration, run-control and status bundle between a sequencer (master)
// and the counter enable controller (slave).
interface count_enable_ctrl_if
  import count_ctrl_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
);
  logic [DIV_W-1:0]   cfg_div;
  logic [1:0]         cfg_mode;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               cnt_overflow;
  logic               enable;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] ticks_issued;

  modport master (
    output cfg_div, cfg_mode, cfg_burst, start, stop, cnt_overflow,
    input  enable, busy, done, ticks_issued
  );

  modport slave (
    input  cfg_div, cfg_mode, cfg_burst, start, stop, cnt_overflow,
    output enable, busy, done, ticks_issued
  );
endinterface

// File: rtl/count_enable_ctrl_tick_prescaler.sv
// Programmable clock divider: tick is high for one cycle every div+1 cycles
// while run is set; clr restarts the count from zero.
module tick_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] pre;

  assign tick = run && (pre == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (run) begin
      if (pre == div) pre <= '0;
      else            pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/count_enable_ctrl.sv
// Run-control FSM producing the 8-bit test counter's enable strobe:
// continuous, fixed burst, or run until the counter reports overflow.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for start; enable low; ticks_issued holds last run
//   ST_RUN  | prescaler running; strobes issued on each prescaler tick
module count_enable_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  count_enable_ctrl_if.slave bus
);

  state_e             state, state_nx;
  logic [DIV_W-1:0]   div_q, div_nx;
  mode_e              mode_q, mode_nx;
  logic [BURST_W-1:0] burst_q, burst_nx;
  logic [BURST_W-1:0] ticks_q, ticks_nx;
  logic               en_q, en_nx;
  logic               done_q, done_nx;
  logic               busy_q;
  logic               pre_clr;
  logic               tick;
  mode_e              cfg_mode_e;

  assign cfg_mode_e = mode_e'(bus.cfg_mode);

  tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .run  (state == ST_RUN),
    .div  (div_q),
    .tick (tick)
  );

  always_comb begin
    state_nx = state;
    div_nx   = div_q;
    mode_nx  = mode_q;
    burst_nx = burst_q;
    ticks_nx = ticks_q;
    en_nx    = 1'b0;
    done_nx  = 1'b0;
    pre_clr  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start && !bus.stop && mode_is_valid(cfg_mode_e)) begin
          div_nx   = bus.cfg_div;
          mode_nx  = cfg_mode_e;
          burst_nx = bus.cfg_burst;
          ticks_nx = '0;
          pre_clr  = 1'b1;
          // An empty burst completes immediately without entering RUN.
          if (cfg_mode_e == MODE_BURST && bus.cfg_burst == '0) done_nx  = 1'b1;
          else                                                 state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_nx = ST_IDLE;
          pre_clr  = 1'b1;
        end else if (mode_q == MODE_OVF && bus.cnt_overflow) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
          pre_clr  = 1'b1;
        end else if (tick) begin
          en_nx    = 1'b1;
          ticks_nx = (&ticks_q) ? ticks_q : ticks_q + 1'b1;
          // Final burst strobe and done leave on the same edge.
          if (mode_q == MODE_BURST && ticks_q == burst_q - 1'b1) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
            pre_clr  = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_q   <= '0;
      mode_q  <= MODE_CONT;
      burst_q <= '0;
      ticks_q <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      div_q   <= div_nx;
      mode_q  <= mode_nx;
      burst_q <= burst_nx;
      ticks_q <= ticks_nx;
      en_q    <= en_nx;
      done_q  <= done_nx;
      busy_q  <= (state_nx == ST_RUN);
    end
  end

  assign bus.enable       = en_q;
  assign bus.done         = done_q;
  assign bus.busy         = busy_q;
  assign bus.ticks_issued = ticks_q;

endmodule
